// File: rtl/clcd_i2c_reader.sv
`default_nettype none
// ============================================================================
// clcd_i2c_reader : reads one HD44780 byte (IR or DR) through a PCF8574 backpack
// Revision 1.0
// ============================================================================
module clcd_i2c_reader #(
  parameter logic [6:0] I2C_ADDR  = 7'h27,
  parameter logic       BACKLIGHT = 1'b1,
  parameter int         MAX_POLL  = 255
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       i_busy,
  input  logic [7:0] i_rdata,
  output logic       o_valid,
  output logic       o_RW,
  output logic [7:0] o_data,
  output logic [6:0] o_addr,
  input  logic       i_req,
  input  logic       i_RS,
  input  logic       i_poll,
  output logic [7:0] o_rdata,
  output logic       o_done,
  output logic       o_timeout,
  output logic       o_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EH_H  = 3'd1;
  localparam logic [2:0] S_RD_H  = 3'd2;
  localparam logic [2:0] S_EL_H  = 3'd3;
  localparam logic [2:0] S_EH_L  = 3'd4;
  localparam logic [2:0] S_RD_L  = 3'd5;
  localparam logic [2:0] S_EL_L  = 3'd6;
  localparam logic [2:0] S_CHECK = 3'd7;

  localparam logic [7:0] C_MAX_POLL = 8'(MAX_POLL);

  logic [2:0] state_q, state_d;
  logic       busy_prev_q;
  logic       launched_q, launched_d;
  logic       seen_rise_q, seen_rise_d;
  logic       valid_q, valid_d;
  logic       rw_q, rw_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rdata_q, rdata_d;
  logic       timeout_q, timeout_d;
  logic       rs_q, rs_d;
  logic       poll_q, poll_d;
  logic [7:0] cnt_q, cnt_d;

  logic w_rise, w_fall, w_rd_phase, w_e_bit, w_bus_phase, w_phase_done;
  logic w_retry, w_give_up, w_unused_rdata;

  assign w_rise         = i_busy & ~busy_prev_q;
  assign w_fall         = ~i_busy & busy_prev_q;
  assign w_rd_phase     = (state_q == S_RD_H) || (state_q == S_RD_L);
  assign w_e_bit        = (state_q == S_EH_H) || (state_q == S_EH_L);
  assign w_bus_phase    = (state_q != S_IDLE) && (state_q != S_CHECK);
  // A fall only completes a phase once this phase's own rise has been seen.
  assign w_phase_done   = w_bus_phase & launched_q & seen_rise_q & w_fall;
  assign w_retry        = (state_q == S_CHECK) & poll_q & rdata_q[7] & (cnt_q < C_MAX_POLL);
  assign w_give_up      = (state_q == S_CHECK) & poll_q & rdata_q[7] & (cnt_q >= C_MAX_POLL);
  assign w_unused_rdata = &{1'b0, i_rdata[3:0]};

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q     <= S_IDLE;
      busy_prev_q <= 1'b0;
      launched_q  <= 1'b0;
      seen_rise_q <= 1'b0;
      valid_q     <= 1'b0;
      rw_q        <= 1'b0;
      data_q      <= 8'h00;
      rdata_q     <= 8'h00;
      timeout_q   <= 1'b0;
      rs_q        <= 1'b0;
      poll_q      <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      busy_prev_q <= i_busy;
      launched_q  <= launched_d;
      seen_rise_q <= seen_rise_d;
      valid_q     <= valid_d;
      rw_q        <= rw_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      timeout_q   <= timeout_d;
      rs_q        <= rs_d;
      poll_q      <= poll_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_req) state_d = S_EH_H;
      S_EH_H:  if (w_phase_done) state_d = S_RD_H;
      S_RD_H:  if (w_phase_done) state_d = S_EL_H;
      S_EL_H:  if (w_phase_done) state_d = S_EH_L;
      S_EH_L:  if (w_phase_done) state_d = S_RD_L;
      S_RD_L:  if (w_phase_done) state_d = S_EL_L;
      S_EL_L:  if (w_phase_done) state_d = S_CHECK;
      default: state_d = w_retry ? S_EH_H : S_IDLE;
    endcase
  end

  always_comb begin
    launched_d  = launched_q;
    seen_rise_d = seen_rise_q;
    valid_d     = valid_q;
    rw_d        = rw_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    timeout_d   = timeout_q;
    rs_d        = rs_q;
    poll_d      = poll_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          rs_d        = i_RS & ~i_poll;
          poll_d      = i_poll;
          timeout_d   = 1'b0;
          cnt_d       = 8'd1;
          launched_d  = 1'b0;
          seen_rise_d = 1'b0;
        end
      end
      S_CHECK: begin
        if (w_retry)   cnt_d     = cnt_q + 8'd1;
        if (w_give_up) timeout_d = 1'b1;
      end
      default: begin
        if (!launched_q) begin
          launched_d = 1'b1;
          valid_d    = 1'b1;
          // Read phases keep the previous expander byte on o_data.
          if (w_rd_phase) begin
            rw_d = 1'b1;
          end else begin
            rw_d   = 1'b0;
            data_d = {4'hF, BACKLIGHT, w_e_bit, 1'b1, rs_q};
          end
        end else if (w_rise) begin
          valid_d     = 1'b0;
          seen_rise_d = 1'b1;
        end else if (w_phase_done) begin
          launched_d  = 1'b0;
          seen_rise_d = 1'b0;
          if (state_q == S_RD_H) rdata_d[7:4] = i_rdata[7:4];
          if (state_q == S_RD_L) rdata_d[3:0] = i_rdata[7:4];
        end
      end
    endcase
  end

  always_comb begin
    o_valid   = valid_q;
    o_RW      = rw_q;
    o_data    = data_q;
    o_addr    = I2C_ADDR;
    o_rdata   = rdata_q;
    o_timeout = timeout_q;
    o_done    = (state_q == S_CHECK) & ~w_retry;
    o_busy    = (state_q != S_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_clcd_i2c_reader.sv
`default_nettype none
// ============================================================================
// tb_clcd_i2c_reader : I2C master responder plus transaction-level reference
// Revision 1.0
// ============================================================================
module tb_clcd_i2c_reader;
  localparam int MAXP = 3;

  logic       clk = 1'b0;
  logic       reset_p, i_busy, i_req, i_RS, i_poll;
  logic [7:0] i_rdata;
  logic       o_valid, o_RW, o_done, o_timeout, o_busy;
  logic [7:0] o_data, o_rdata;
  logic [6:0] o_addr;

  always #5 clk = ~clk;

  clcd_i2c_reader #(.I2C_ADDR(7'h27), .BACKLIGHT(1'b1), .MAX_POLL(MAXP)) dut (
    .clk(clk), .reset_p(reset_p), .i_busy(i_busy), .i_rdata(i_rdata),
    .o_valid(o_valid), .o_RW(o_RW), .o_data(o_data), .o_addr(o_addr),
    .i_req(i_req), .i_RS(i_RS), .i_poll(i_poll), .o_rdata(o_rdata),
    .o_done(o_done), .o_timeout(o_timeout), .o_busy(o_busy)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] tr_log [0:2047];
  int         tr_n = 0;
  logic [7:0] rsp_arr [0:1023];
  int         rsp_rd = 0;
  int         rise_fix = -1;
  bit         spur_mode = 1'b0;
  bit         mst_active = 1'b0;
  int         done_cnt = 0;
  logic [7:0] plan [0:5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Master responder: logs each request as {RW, data} and answers reads from rsp_arr.
  initial begin : master
    bit   armed;
    int   dly;
    logic rw;
    armed   = 1'b0;
    i_busy  = 1'b0;
    i_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (spur_mode && !armed && !o_valid && !o_busy) begin
        i_busy = 1'b1;
        armed  = 1'b1;
      end else if (o_valid) begin
        mst_active = 1'b1;
        rw = o_RW;
        tr_log[tr_n % 2048] = {o_RW, o_data};
        tr_n++;
        if (armed) begin
          i_busy = 1'b0;
          armed  = 1'b0;
          repeat (2) @(negedge clk);
        end
        dly = (rise_fix >= 0) ? rise_fix : int'($urandom_range(0, 3));
        repeat (dly) @(negedge clk);
        i_busy = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        if (rw) begin
          i_rdata = rsp_arr[rsp_rd % 1024];
          rsp_rd++;
        end
        i_busy = 1'b0;
        mst_active = 1'b0;
      end
    end
  end

  always @(negedge clk) if (o_done === 1'b1) done_cnt++;

  // Reference: expected bus transactions, byte and timeout from the read/poll rules.
  task automatic do_req(input bit rs, input bit poll, input bit mid_pulse,
                        input bit done_req, input string tag);
    logic [8:0] exp_q[$];
    logic [7:0] b, e_hi, e_lo, exp_rd;
    bit         ers, exp_to;
    int         it, tr_base, d_base, rb, cyc, ntr;
    ers    = poll ? 1'b0 : rs;
    e_hi   = {4'hF, 1'b1, 1'b1, 1'b1, ers};
    e_lo   = {4'hF, 1'b1, 1'b0, 1'b1, ers};
    rb     = rsp_rd;
    for (int k = 0; k < 6; k++) rsp_arr[(rb + k) % 1024] = plan[k];
    it     = 0;
    exp_to = 1'b0;
    exp_rd = 8'h00;
    while (it < MAXP) begin
      b = {plan[2*it][7:4], plan[2*it+1][7:4]};
      it++;
      exp_q.push_back({1'b0, e_hi});
      exp_q.push_back({1'b1, e_hi});
      exp_q.push_back({1'b0, e_lo});
      exp_q.push_back({1'b0, e_hi});
      exp_q.push_back({1'b1, e_hi});
      exp_q.push_back({1'b0, e_lo});
      exp_rd = b;
      if (!poll || !b[7]) break;
      if (it == MAXP) exp_to = 1'b1;
    end
    tr_base = tr_n;
    d_base  = done_cnt;
    @(negedge clk);
    i_req = 1'b1; i_RS = rs; i_poll = poll;
    @(negedge clk);
    i_req = 1'b0;
    chk({tag, "_busy_hi"}, o_busy, 1);
    chk({tag, "_to_clr"}, o_timeout, 0);
    for (cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      i_req = 1'b0;
      if (mid_pulse && cyc == 7) begin
        i_req = 1'b1; i_RS = ~rs; i_poll = ~poll;
      end
      if (done_req && o_done) i_req = 1'b1;
      if (!o_busy) break;
    end
    chk({tag, "_finish"}, cyc < 4000, 1);
    repeat (6) @(negedge clk);
    chk({tag, "_idle"}, o_busy, 0);
    chk({tag, "_done_cnt"}, done_cnt - d_base, 1);
    ntr = tr_n - tr_base;
    chk({tag, "_ntr"}, ntr, exp_q.size());
    for (int k = 0; k < exp_q.size() && k < ntr; k++)
      chk($sformatf("%s_tr%0d", tag, k), tr_log[(tr_base + k) % 2048], exp_q[k]);
    chk({tag, "_rdata"}, o_rdata, exp_rd);
    chk({tag, "_timeout"}, o_timeout, exp_to);
    chk({tag, "_valid"}, o_valid, 0);
  endtask

  task automatic set_plan(input logic [7:0] a0, a1, a2, a3, a4, a5);
    plan[0] = a0; plan[1] = a1; plan[2] = a2; plan[3] = a3; plan[4] = a4; plan[5] = a5;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  b, k, rb;
    bit  vseen;
    reset_p = 1'b1; i_req = 1'b0; i_RS = 1'b0; i_poll = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_rw", o_RW, 0);
    chk("rst_data", o_data, 0);
    chk("rst_addr", o_addr, 7'h27);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_done", o_done, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_busy", o_busy, 0);
    reset_p = 1'b0;
    repeat (2) @(negedge clk);

    set_plan(8'hA0, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00);
    do_req(1'b1, 1'b0, 1'b0, 1'b0, "dr_read");
    set_plan(8'h80, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00);
    do_req(1'b0, 1'b0, 1'b0, 1'b0, "ir_read");
    set_plan(8'h80, 8'h00, 8'h80, 8'h00, 8'h00, 8'h40);
    do_req(1'b1, 1'b1, 1'b0, 1'b0, "poll_ok");
    set_plan(8'h80, 8'h00, 8'hF0, 8'hF0, 8'h90, 8'h10);
    do_req(1'b0, 1'b1, 1'b0, 1'b0, "poll_to");
    set_plan(8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00);
    do_req(1'b1, 1'b0, 1'b0, 1'b1, "req_at_done");

    // Late busy rise: o_valid must hold until the rise, then drop one cycle later.
    set_plan(8'h5A, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00);
    rise_fix = 5;
    b = tr_n;
    fork
      do_req(1'b1, 1'b0, 1'b0, 1'b0, "rise5");
      begin
        for (int c = 0; c < 500 && tr_n == b; c++) begin @(negedge clk); #1; end
        chk("rise5_seen", tr_n > b, 1);
        rise_fix = -1;
        k = 0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk); #1;
          k++;
          if (i_busy) break;
        end
        chk("rise5_delay", k, 5);
        chk("rise5_valid_at_rise", o_valid, 1);
        @(negedge clk); #1;
        chk("rise5_valid_drop", o_valid, 0);
      end
    join

    // Busy already high on entry: its fall is not a completion.
    spur_mode = 1'b1;
    repeat (3) @(negedge clk);
    set_plan(8'h60, 8'h90, 8'h00, 8'h00, 8'h00, 8'h00);
    b = tr_n;
    fork
      do_req(1'b0, 1'b0, 1'b1, 1'b0, "spur");
      begin
        for (int c = 0; c < 500 && tr_n == b; c++) begin @(negedge clk); #1; end
        spur_mode = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("spur_valid_held", o_valid, 1);
        chk("spur_rw_held", o_RW, 0);
      end
    join

    // Reset while the low-nibble read is outstanding.
    rb = rsp_rd;
    rsp_arr[rb % 1024]       = 8'hE0;
    rsp_arr[(rb + 1) % 1024] = 8'h70;
    b = tr_n;
    @(negedge clk);
    i_req = 1'b1; i_RS = 1'b1; i_poll = 1'b0;
    @(negedge clk);
    i_req = 1'b0;
    for (int c = 0; c < 2000 && (tr_n - b) < 5; c++) begin @(negedge clk); #1; end
    chk("rstmid_reached", tr_n - b, 5);
    reset_p = 1'b1;
    @(negedge clk);
    reset_p = 1'b0;
    chk("rstmid_valid", o_valid, 0);
    chk("rstmid_rw", o_RW, 0);
    chk("rstmid_data", o_data, 0);
    chk("rstmid_rdata", o_rdata, 0);
    chk("rstmid_busy", o_busy, 0);
    chk("rstmid_done", o_done, 0);
    vseen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vseen = vseen | o_valid;
    end
    chk("rstmid_no_valid", vseen, 0);
    for (int c = 0; c < 200 && (mst_active || i_busy); c++) @(negedge clk);
    set_plan(8'h40, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00);
    do_req(1'b1, 1'b0, 1'b0, 1'b0, "post_rst");

    for (int n = 0; n < 12; n++) begin
      for (int j = 0; j < 6; j++) plan[j] = 8'($urandom);
      do_req(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
